// File: rtl/seg7_star_control.sv
`default_nettype none
// ============================================================================
// Module      : seg7_star_control
// Description : Scans two 4-digit multiplexed 7-segment displays from eight
//               6-bit character codes. Each digit can blink between its
//               normal code/dp and an alternate code/dp. The live blink
//               state is exported per digit.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_star_control #(
  parameter int SCAN_DIV   = 100_000,
  parameter int BLINK_HALF = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] x,
  input  logic [7:0]  dp,
  input  logic [47:0] xstar,
  input  logic [7:0]  dpstar,
  input  logic [7:0]  star,
  output logic [6:0]  a_to_g1,
  output logic [3:0]  an1,
  output logic        dp1,
  output logic [6:0]  a_to_g2,
  output logic [3:0]  an2,
  output logic        dp2,
  output logic [7:0]  staring
);

  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [5:0] C_CODE_BANG = 6'd38;

  logic [SCAN_W-1:0]  r_scan_cnt;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic [1:0]         r_slot;
  logic               r_phase;

  logic [5:0] w_code [8];
  logic       w_dp   [8];
  logic [5:0] w_code1, w_code2;
  logic       w_dp1, w_dp2;

  // Code to segment pattern, a..g MSB-first, 1 = lit.
  function automatic logic [6:0] seg_of(input logic [5:0] code);
    logic [6:0] s;
    case (code)
      6'd0:  s = 7'h7E;  6'd1:  s = 7'h30;  6'd2:  s = 7'h6D;  6'd3:  s = 7'h79;
      6'd4:  s = 7'h33;  6'd5:  s = 7'h5B;  6'd6:  s = 7'h5F;  6'd7:  s = 7'h70;
      6'd8:  s = 7'h7F;  6'd9:  s = 7'h7B;  6'd10: s = 7'h77;  6'd11: s = 7'h1F;
      6'd12: s = 7'h4E;  6'd13: s = 7'h3D;  6'd14: s = 7'h4F;  6'd15: s = 7'h47;
      6'd16: s = 7'h5E;  6'd17: s = 7'h37;  6'd18: s = 7'h06;  6'd19: s = 7'h3C;
      6'd20: s = 7'h2F;  6'd21: s = 7'h0E;  6'd22: s = 7'h54;  6'd23: s = 7'h15;
      6'd24: s = 7'h1D;  6'd25: s = 7'h67;  6'd26: s = 7'h73;  6'd27: s = 7'h05;
      6'd28: s = 7'h5B;  6'd29: s = 7'h0F;  6'd30: s = 7'h3E;  6'd31: s = 7'h1C;
      6'd32: s = 7'h2A;  6'd33: s = 7'h37;  6'd34: s = 7'h3B;  6'd35: s = 7'h6D;
      6'd36: s = 7'h01;  6'd37: s = 7'h08;  6'd38: s = 7'h20;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Per-digit choice between normal and alternate field, driven by the shared phase.
  generate
    for (genvar i = 0; i < 8; i++) begin : g_digit
      assign w_code[i] = (star[i] && r_phase) ? xstar[6*i +: 6] : x[6*i +: 6];
      assign w_dp[i]   = (star[i] && r_phase) ? dpstar[i]       : dp[i];
    end
  endgenerate

  // Slot k shows digit 4+k on display 1 and digit k on display 2.
  always_comb begin
    w_code1 = w_code[{1'b1, r_slot}];
    w_code2 = w_code[{1'b0, r_slot}];
    w_dp1   = w_dp[{1'b1, r_slot}] | (w_code1 == C_CODE_BANG);
    w_dp2   = w_dp[{1'b0, r_slot}] | (w_code2 == C_CODE_BANG);
  end

  // Scan and blink timebases plus registered display pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_cnt  <= '0;
      r_blink_cnt <= '0;
      r_slot      <= '0;
      r_phase     <= 1'b0;
      a_to_g1     <= '0;
      an1         <= '0;
      dp1         <= 1'b0;
      a_to_g2     <= '0;
      an2         <= '0;
      dp2         <= 1'b0;
      staring     <= '0;
    end else begin
      if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        r_scan_cnt <= '0;
        r_slot     <= r_slot + 2'd1;
      end else begin
        r_scan_cnt <= r_scan_cnt + 1'b1;
      end

      if (r_blink_cnt == BLINK_W'(BLINK_HALF - 1)) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end

      a_to_g1 <= seg_of(w_code1);
      a_to_g2 <= seg_of(w_code2);
      dp1     <= w_dp1;
      dp2     <= w_dp2;
      an1     <= 4'b0001 << r_slot;
      an2     <= 4'b0001 << r_slot;
      staring <= star & {8{r_phase}};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_star_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_star_control
// Description : Directed self-checking bench for seg7_star_control with
//               SCAN_DIV=4 and BLINK_HALF=64.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_star_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] x;
  logic [7:0]  dp;
  logic [47:0] xstar;
  logic [7:0]  dpstar;
  logic [7:0]  star;
  logic [6:0]  a_to_g1, a_to_g2;
  logic [3:0]  an1, an2;
  logic        dp1, dp2;
  logic [7:0]  staring;

  int checks = 0;
  int errors = 0;
  // n = number of rising edges since reset was last released
  int n = 0;

  seg7_star_control #(.SCAN_DIV(4), .BLINK_HALF(64)) dut (
    .clk(clk), .rst(rst), .x(x), .dp(dp), .xstar(xstar), .dpstar(dpstar),
    .star(star), .a_to_g1(a_to_g1), .an1(an1), .dp1(dp1),
    .a_to_g2(a_to_g2), .an2(an2), .dp2(dp2), .staring(staring)
  );

  always #5 clk = ~clk;

  // Edge counter used to place each directed check on a known slot/phase.
  always @(posedge clk) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (n=%0d)", tag, obs, exp, n);
    end
  endtask

  task automatic set_digit(input int i, input int code);
    x[6*i +: 6] = 6'(code);
  endtask

  // Advance on falling edges until the edge counter reaches target.
  task automatic wait_n(input int target);
    if (n > target) check("schedule", 64'(n), 64'(target));
    while (n < target) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n=%0d", n);
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    x      = '0;
    xstar  = {48{1'b1}};
    dp     = 8'h00;
    dpstar = 8'h00;
    star   = 8'h00;
    // "SUCCESS!": display 1 digits 4..7 = S U C C, display 2 digits 3..0 = E S S !
    set_digit(4, 28); set_digit(5, 30); set_digit(6, 12); set_digit(7, 12);
    set_digit(3, 14); set_digit(2, 28); set_digit(1, 28); set_digit(0, 38);

    // 1. reset
    repeat (3) @(negedge clk);
    check("rst_a_to_g1", 64'(a_to_g1), 64'h00);
    check("rst_a_to_g2", 64'(a_to_g2), 64'h00);
    check("rst_an1",     64'(an1),     64'h0);
    check("rst_an2",     64'(an2),     64'h0);
    check("rst_dp",      64'({dp1, dp2}), 64'h0);
    check("rst_staring", 64'(staring), 64'h00);
    rst = 1'b0;
    @(negedge clk);
    check("first_an1", 64'(an1), 64'h1);
    check("first_an2", 64'(an2), 64'h1);
    wait_n(4);
    check("slot0_hold_an2", 64'(an2), 64'h1);
    wait_n(5);
    check("second_an1", 64'(an1), 64'h2);
    check("second_an2", 64'(an2), 64'h2);

    // 2. SUCCESS! across all four slots
    wait_n(6);
    check("s1_a_to_g1", 64'(a_to_g1), 64'h3E);
    check("s1_a_to_g2", 64'(a_to_g2), 64'h5B);
    wait_n(9);
    check("s2_a_to_g1", 64'(a_to_g1), 64'h4E);
    check("s2_a_to_g2", 64'(a_to_g2), 64'h5B);
    wait_n(13);
    check("s3_a_to_g1", 64'(a_to_g1), 64'h4E);
    check("s3_a_to_g2", 64'(a_to_g2), 64'h4F);
    check("s3_an1",     64'(an1),     64'h8);
    wait_n(17);
    check("s0_a_to_g1", 64'(a_to_g1), 64'h5B);
    check("s0_a_to_g2", 64'(a_to_g2), 64'h20);
    check("s0_dp2_bang", 64'(dp2), 64'h1);
    check("s0_dp1",     64'(dp1), 64'h0);

    // 3. digit0 = 8 blinking against blank
    set_digit(0, 8);
    star = 8'h01;
    wait_n(33);
    check("blink_p0_a_to_g2", 64'(a_to_g2), 64'h7F);
    check("blink_p0_staring", 64'(staring), 64'h00);
    wait_n(64);
    check("blink_edge_before", 64'(staring), 64'h00);
    wait_n(65);
    check("blink_edge_after",  64'(staring), 64'h01);
    check("blink_p1_a_to_g2",  64'(a_to_g2), 64'h00);
    check("blink_p1_a_to_g1",  64'(a_to_g1), 64'h5B);
    wait_n(128);
    check("blink_p1_end",      64'(staring), 64'h01);
    wait_n(129);
    check("blink_p2_staring",  64'(staring), 64'h00);
    check("blink_p2_a_to_g2",  64'(a_to_g2), 64'h7F);

    // 4. dp of digit 7 follows ~phase
    dp = 8'h80; dpstar = 8'h00; star = 8'h80;
    wait_n(141);
    check("dp1_s3_p0", 64'(dp1), 64'h1);
    check("dp2_s3_p0", 64'(dp2), 64'h0);
    wait_n(145);
    check("dp1_s0_p0", 64'(dp1), 64'h0);
    wait_n(197);
    check("dp1_s1_p1", 64'(dp1), 64'h0);
    wait_n(205);
    check("dp1_s3_p1", 64'(dp1), 64'h0);
    check("staring_d7", 64'(staring), 64'h80);

    // 5. drop star[0] during phase 1
    star = 8'h01;
    wait_n(206);
    check("star0_on", 64'(staring), 64'h01);
    wait_n(209);
    check("star0_blank", 64'(a_to_g2), 64'h00);
    star = 8'h00;
    wait_n(210);
    check("star0_drop_staring", 64'(staring), 64'h00);
    check("star0_drop_seg",     64'(a_to_g2), 64'h7F);

    // 6. punctuation and blank codes
    set_digit(0, 36); set_digit(1, 37); set_digit(2, 39); set_digit(3, 63);
    wait_n(225);
    check("code36", 64'(a_to_g2), 64'h01);
    check("code36_dp", 64'(dp2), 64'h0);
    wait_n(229);
    check("code37", 64'(a_to_g2), 64'h08);
    wait_n(233);
    check("code39", 64'(a_to_g2), 64'h00);
    wait_n(237);
    check("code63", 64'(a_to_g2), 64'h00);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      check("onehot_an1", 64'(an1), 64'(4'b0001 << (((n - 1) / 4) % 4)));
      check("onehot_an2", 64'(an2), 64'(4'b0001 << (((n - 1) / 4) % 4)));
    end

    // Mid-run reset restarts both timebases
    star = 8'h01;
    wait_n(650);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_an1",     64'(an1),     64'h0);
    check("midrst_a_to_g2", 64'(a_to_g2), 64'h00);
    check("midrst_staring", 64'(staring), 64'h00);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_an2",     64'(an2),     64'h1);
    check("midrst_seg",     64'(a_to_g2), 64'h01);
    wait_n(64);
    check("midrst_blink_before", 64'(staring), 64'h00);
    wait_n(65);
    check("midrst_blink_after",  64'(staring), 64'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
